// File: rtl/fmul_pkg.sv
// Shared types and constants for the float-multiplier sharing controller.
package fmul_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned FLG_W     = 3;
    localparam int unsigned FLG_EXC   = 2;
    localparam int unsigned FLG_OVF   = 1;
    localparam int unsigned FLG_UNF   = 0;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned IDX_MAX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
        logic [FLG_W-1:0]     flags;
    } tag_t;

endpackage

// File: rtl/fmul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic        found;
        int unsigned cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                gnt_idx              = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Shares one pipelined float multiplier among N_REQ requesters and routes
// each product, with its latency-aligned flags, back to the issuing requester.
module fmul_share_ctrl
    import fmul_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned OUT_LAT  = 2,
    parameter int unsigned FLAG_LAT = 1,
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CW = $clog2(OUT_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [FP_W-1:0]       mul_a,
    output logic [FP_W-1:0]       mul_b,
    input  logic [FP_W-1:0]       mul_out,
    input  logic                  mul_exc,
    input  logic                  mul_ovf,
    input  logic                  mul_unf,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_data,
    output logic [FLG_W-1:0]      rsp_flags,
    output logic [CW-1:0]         inflight
);

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             issue;
    logic             ret;
    logic [FLG_W-1:0] mul_flags;
    logic [CW-1:0]    inflight_q, inflight_d;
    tag_t             stage_q [OUT_LAT];
    tag_t             stage_d [OUT_LAT];

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = rst_n ? gnt : '0;
    assign issue     = |req_ready;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                mul_a = req_a[FP_W*i +: FP_W];
                mul_b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        mul_flags          = '0;
        mul_flags[FLG_EXC] = mul_exc;
        mul_flags[FLG_OVF] = mul_ovf;
        mul_flags[FLG_UNF] = mul_unf;
    end

    // Flags are only valid FLAG_LAT cycles after issue, so they are latched as
    // the tag moves out of that stage and then ride along with it.
    always_comb begin
        for (int unsigned i = 0; i < OUT_LAT; i++) begin
            stage_d[i] = stage_q[i];
        end
        stage_d[0].valid = issue;
        stage_d[0].idx   = IDX_MAX_W'(gnt_idx);
        stage_d[0].flags = '0;
        for (int unsigned i = 1; i < OUT_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
            if (i == FLAG_LAT) begin
                stage_d[i].flags = mul_flags;
            end
        end
    end

    // Gated by rst_n so a product still in flight at reset never surfaces.
    assign ret = rst_n & stage_q[OUT_LAT-1].valid;

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_flags = '0;
        if (ret) begin
            rsp_valid = N_REQ'(1) << stage_q[OUT_LAT-1].idx;
            rsp_data  = mul_out;
            rsp_flags = stage_q[OUT_LAT-1].flags;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    assign inflight = inflight_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            for (int unsigned i = 0; i < OUT_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            for (int unsigned i = 0; i < OUT_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed plus randomized bench for fmul_share_ctrl with a behavioural
// multiplier and a queue-based scoreboard.
module tb_fmul_share_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready;
    logic [31:0]  mul_a, mul_b, mul_out;
    logic         mul_exc, mul_ovf, mul_unf;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [2:0]   rsp_flags;
    logic [1:0]   inflight;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr_m    = 0;
    int peak     = 0;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } op_t;
    op_t q[$];

    always #5 clk = ~clk;

    fmul_share_ctrl #(
        .N_REQ    (4),
        .OUT_LAT  (2),
        .FLAG_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .mul_exc   (mul_exc),
        .mul_ovf   (mul_ovf),
        .mul_unf   (mul_unf),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .inflight  (inflight)
    );

    // Simplified single-precision multiply: zero/denormal inputs flush to 0,
    // truncating rounding. Returns {exc, ovf, unf, product}.
    function automatic logic [34:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'h0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 35'h0;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, 32'h0};
        return {3'b000, s, 8'(e), m};
    endfunction

    // Multiplier stand-in: input register, flags off the input register,
    // product off an output register.
    logic [31:0] ma_q, mb_q, mout_q;
    logic [34:0] mres;
    assign mres = fmul_ref(ma_q, mb_q);
    always @(posedge clk) begin
        ma_q   <= mul_a;
        mb_q   <= mul_b;
        mout_q <= mres[31:0];
    end
    assign mul_out = mout_q;
    assign mul_exc = mres[34];
    assign mul_ovf = mres[33];
    assign mul_unf = mres[32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_cycle(input logic rn, input logic [3:0] v,
                            input logic [127:0] a, input logic [127:0] b);
        int          g;
        int          c;
        logic [3:0]  er, ev;
        logic [31:0] ea, eb, ed;
        logic [2:0]  ef;
        logic [34:0] r;
        rst_n     = rn;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        g = -1;
        if (rn) begin
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        er = 4'h0;
        ea = 32'h0;
        eb = 32'h0;
        if (g >= 0) begin
            er = 4'(1 << g);
            ea = a[32*g +: 32];
            eb = b[32*g +: 32];
        end
        ev = 4'h0;
        ed = 32'h0;
        ef = 3'h0;
        if (rn && q.size() > 0 && q[0].due == cyc) begin
            r  = fmul_ref(q[0].a, q[0].b);
            ev = 4'(1 << q[0].idx);
            ed = r[31:0];
            ef = r[34:32];
        end
        check("req_ready", 64'(req_ready), 64'(er));
        check("mul_a", 64'(mul_a), 64'(ea));
        check("mul_b", 64'(mul_b), 64'(eb));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        check("rsp_data", 64'(rsp_data), 64'(ed));
        check("rsp_flags", 64'(rsp_flags), 64'(ef));
        if (cyc > 0) begin
            check("inflight", 64'(inflight), 64'(q.size()));
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        @(posedge clk);
        cyc++;
        if (!rn) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc - 1) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, ea, eb, cyc + 1});
                ptr_m = (g + 1) % N;
            end
        end
        #1;
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [127:0] z;
        z = '0;

        // Reset with all requesters asserting: no grants may leak out.
        do_cycle(1'b0, 4'hF, z, z);
        do_cycle(1'b0, 4'hF, z, z);
        // Idle.
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);

        // Single request from requester 2: 1.5 * 2.0.
        do_cycle(1'b1, 4'b0100, {32'h0, 32'h3FC00000, 64'h0}, {32'h0, 32'h40000000, 64'h0});
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);

        // Re-reset, then all four valid for 8 cycles.
        do_cycle(1'b0, 4'h0, z, z);
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 4'hF,
                     {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800000},
                     {32'h3F800000, 32'h40400000, 32'h40800000, 32'h40A00000});
        end
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);
        check("inflight_peak", 64'(peak), 64'd2);

        // Overflow returned to requester 1.
        do_cycle(1'b1, 4'b0010, {64'h0, 32'h7F000000, 32'h0}, {64'h0, 32'h7F000000, 32'h0});
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);

        // Exception followed immediately by a clean operation.
        do_cycle(1'b1, 4'b0001, {96'h0, 32'h7F800000}, {96'h0, 32'h3F800000});
        do_cycle(1'b1, 4'b0001, {96'h0, 32'h3F800000}, {96'h0, 32'h3F800000});
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);

        // Reset mid-flight: two issues, then one reset cycle.
        do_cycle(1'b1, 4'b1000, {32'h40000000, 96'h0}, {32'h40000000, 96'h0});
        do_cycle(1'b1, 4'b1000, {32'h40400000, 96'h0}, {32'h40400000, 96'h0});
        do_cycle(1'b0, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'hF, {4{32'h3F800000}}, {4{32'h40000000}});
        do_cycle(1'b1, 4'h0, z, z);
        do_cycle(1'b1, 4'h0, z, z);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            do_cycle(1'b1, 4'($urandom), ra, rb);
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'h0, z, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
